apb_multi_slave_system: RTL and testbench

APB_MULTI_SLAVE_SYSTEM -- requirements
Module: apb_multi_slave_system

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_mem_slave.sv | 62 ++++++
 rtl/apb_multi_slave_system.sv | 137 +++++++++++++
 tb/tb_apb_multi_slave_system.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and address-decode helpers for the APB multi-slave system.
// The bridge and the memory slaves both import this package.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Slave index field width and wait-state counter width
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  // The slave index sits directly above the word offset and the two byte bits
  function automatic int slave_sel_lsb(input int off_w);
    return off_w + 2;
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

  function automatic logic high_bits_set(input logic [63:0] addr, input int first_bit);
    return (addr >> first_bit) != 64'd0;
  endfunction

endpackage

// File: rtl/apb_mem_slave.sv
// Word-addressed APB memory peripheral with byte strobes and a fixed number
// of wait states; contents clear on reset so the array is built from flops.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  localparam int OFF_W      = $clog2(DEPTH),
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [OFF_W-1:0]  poffset,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              access;
  logic              done;

  assign access = psel && penable;
  assign done   = access && (cnt_reg == CNT_W'(WAIT_STATES));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_reg <= '0;
    end else if (done) begin
      cnt_reg <= '0;
    end else if (access) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Writes land only on the completing cycle, one byte lane per strobe bit
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (done && pwrite) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (pstrb[k]) begin
          mem_reg[poffset][k*8 +: 8] <= pwdata[k*8 +: 8];
        end
      end
    end
  end

  assign pready  = done;
  assign prdata  = (done && !pwrite) ? mem_reg[poffset] : '0;
  assign pslverr = 1'b0;

endmodule

// File: rtl/apb_multi_slave_system.sv
// APB bridge FSM with address decode in front of NUM_SLAVES memory slaves.
// Bad addresses are answered by the bridge itself with an immediate error.
module apb_multi_slave_system
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              ptransfer,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int OFF_W    = $clog2(DEPTH);
  localparam int SEL_LSB  = slave_sel_lsb(OFF_W);
  localparam int HIGH_LSB = SEL_LSB + SEL_W;

  apb_state_e        state_reg, state_next;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] strb_reg;

  logic              capture;
  logic [63:0]       addr_ext;
  logic [SEL_W-1:0]  sel_idx;
  logic [OFF_W-1:0]  offset;
  logic              addr_err;
  logic              penable;
  logic [15:0]       psel;

  logic              slv_pready  [16];
  logic              slv_pslverr [16];
  logic [DATA_W-1:0] slv_prdata  [16];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ptransfer) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready) state_next = ptransfer ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen on every entry to SETUP
  assign capture = ((state_reg == IDLE) && ptransfer) ||
                   ((state_reg == ACCESS) && pready && ptransfer);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (capture) begin
      write_reg <= pwrite;
      addr_reg  <= paddr;
      wdata_reg <= pwdata;
      strb_reg  <= pstrb;
    end
  end

  assign addr_ext = 64'(addr_reg);
  assign sel_idx  = SEL_W'(addr_ext >> SEL_LSB);
  assign offset   = addr_reg[OFF_W+1:2];
  assign addr_err = misaligned(addr_reg[1:0]) ||
                    ({1'b0, sel_idx} >= (SEL_W+1)'(NUM_SLAVES)) ||
                    high_bits_set(addr_ext, HIGH_LSB);
  assign penable  = (state_reg == ACCESS);

  for (genvar gi = 0; gi < 16; gi++) begin : g_slot
    if (gi < NUM_SLAVES) begin : g_slv
      assign psel[gi] = (state_reg != IDLE) && !addr_err && (sel_idx == SEL_W'(gi));

      apb_mem_slave #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES)
      ) u_slave (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel[gi]),
        .penable (penable),
        .pwrite  (write_reg),
        .poffset (offset),
        .pwdata  (wdata_reg),
        .pstrb   (strb_reg),
        .prdata  (slv_prdata[gi]),
        .pready  (slv_pready[gi]),
        .pslverr (slv_pslverr[gi])
      );
    end else begin : g_empty
      assign psel[gi]        = 1'b0;
      assign slv_pready[gi]  = 1'b0;
      assign slv_pslverr[gi] = 1'b0;
      assign slv_prdata[gi]  = '0;
    end
  end

  // Return path selected by the registered index; errors short-circuit the slaves
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state_reg == ACCESS) begin
      if (addr_err) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else begin
        pready  = slv_pready[sel_idx];
        pslverr = slv_pslverr[sel_idx];
        prdata  = slv_prdata[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_system.sv
// Bench for apb_multi_slave_system: three instances with 0, 3 and 2 wait states.
// Table vectors plus back-to-back and reset-abort sequences, scoreboard-checked.
module tb_apb_multi_slave_system;

  localparam int N = 3;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        ptransfer [N];
  logic        pwrite    [N];
  logic [31:0] paddr     [N];
  logic [31:0] pwdata    [N];
  logic [3:0]  pstrb     [N];
  logic [31:0] prdata    [N];
  logic        pready    [N];
  logic        pslverr   [N];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int WS = (gi == 1) ? 3 : (gi == 2) ? 2 : 0;
    apb_multi_slave_system #(.WAIT_STATES(WS)) u_dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .ptransfer (ptransfer[gi]),
      .pwrite    (pwrite[gi]),
      .paddr     (paddr[gi]),
      .pwdata    (pwdata[gi]),
      .pstrb     (pstrb[gi]),
      .prdata    (prdata[gi]),
      .pready    (pready[gi]),
      .pslverr   (pslverr[gi])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Call #1 after a rising edge; returns #1 after the edge following completion
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input string name);
    exp_t e;
    int c0, lat;
    logic [31:0] rd;
    logic er;
    bit done;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    ptransfer[d] = 1'b1; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    c0 = cyc;
    @(posedge pclk); #1;
    ptransfer[d] = 1'b0; pwrite[d] = ~wr; paddr[d] = $urandom; pwdata[d] = $urandom; pstrb[d] = 4'hF;
    done = 0; lat = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (pready[d]) begin
        done = 1; lat = cyc - c0; rd = prdata[d]; er = pslverr[d];
      end
    end
    e = sb.pop_front();
    if (!done) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " latency"}, 32'(lat), 32'(e.lat));
      check({name, " prdata"}, rd, e.rdata);
      check({name, " pslverr"}, 32'(er), 32'(e.err));
    end
    $display("xfer %s dut%0d %s addr=0x%08h prdata=0x%08h pslverr=%0d cycles=%0d",
             name, d, wr ? "W" : "R", a, rd, er, lat);
    @(posedge pclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k;
    vt[0]  = '{1'b1, 32'h0000_0404, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h0000_0404, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0808, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h0000_0808, 32'h11223344, 4'h5, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h0000_0808, 32'h0,        4'hF, 32'hAA22CC44, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0808, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h0000_0808, 32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vt[7]  = '{1'b0, 32'h0000_1000, 32'h0,        4'hF, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h0000_0002, 32'h0,        4'hF, 32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h0000_0406, 32'h55555555, 4'hF, 32'h0,        1'b1};
    vt[10] = '{1'b0, 32'h0000_0404, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vt[11] = '{1'b1, 32'h0000_4000, 32'h00000077, 4'hF, 32'h0,        1'b1};
    vt[12] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0,        1'b0};
    vt[13] = '{1'b1, 32'h0000_0C00, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h0000_0C00, 32'h0,        4'hF, 32'h0BADF00D, 1'b0};
    vt[15] = '{1'b0, 32'h0000_0800, 32'h0,        4'hF, 32'h0,        1'b0};
    vt[16] = '{1'b1, 32'h0000_03FC, 32'h13579BDF, 4'hF, 32'h0,        1'b0};
    vt[17] = '{1'b0, 32'h0000_03FC, 32'h0,        4'hF, 32'h13579BDF, 1'b0};

    presetn = 1'b0;
    for (int d = 0; d < N; d++) begin
      ptransfer[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset dut%0d pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("reset dut%0d pslverr", d), 32'(pslverr[d]), 32'd0);
      check($sformatf("reset dut%0d prdata", d), prdata[d], 32'd0);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 18; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].rdata, vt[i].err, 2,
           $sformatf("vec%0d", i));
    end
    xfer(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 32'h0, 1'b0, 2, "slv3_top");

    // Three writes with ptransfer held high: completions every 5 cycles
    c0 = cyc; k = 0;
    ptransfer[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'hA000_0001; pstrb[1] = 4'hF;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge pclk);
      if (pready[1]) begin
        check($sformatf("b2b pulse%0d cycle", k), 32'(cyc - c0), 32'(5 * (k + 1)));
        $display("xfer b2b dut1 W pulse=%0d cycle=%0d", k, cyc - c0);
        k++;
        paddr[1] = 32'h10 + 32'(4 * k);
        pwdata[1] = 32'hA000_0001 + 32'(k);
        if (k == 3) ptransfer[1] = 1'b0;
      end
    end
    check("b2b pulse count", 32'(k), 32'd3);
    @(posedge pclk); #1;
    for (int j = 0; j < 3; j++) begin
      xfer(1, 1'b0, 32'h10 + 32'(4 * j), 32'h0, 4'h0, 32'hA000_0001 + 32'(j), 1'b0, 5,
           $sformatf("b2b_rd%0d", j));
    end

    // Reset dropped in the ACCESS phase of a write with two wait states
    ptransfer[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 32'h10; pwdata[2] = 32'hCAFEF00D; pstrb[2] = 4'hF;
    @(posedge pclk); #1;
    ptransfer[2] = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("abort access pready", 32'(pready[2]), 32'd0);
    presetn = 1'b0;
    #1;
    check("abort rst pready", 32'(pready[2]), 32'd0);
    check("abort rst pslverr", 32'(pslverr[2]), 32'd0);
    check("abort rst prdata", prdata[2], 32'd0);
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 4, "abort_rd");
    xfer(0, 1'b0, 32'h0000_0404, 32'h0, 4'hF, 32'h0, 1'b0, 2, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
